retire_trace_buffer: RTL
========================

Name: retire_trace_buffer

Overview:
- Sits directly downstream of the single-cycle cpu's commit signals, one retired instruction per clk.
- Classifies each cycle's commit as a REG-write, STORE, NOP/branch or HALT record, stamps it with an instruction number and queues it in a FIFO.
- Records drain over a valid/ready port to the trace sink, which is a file writer in simulation or a debug UART on the board.
- Also keeps the cycle and instruction counters and the runaway-cycle timeout.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- MAX_CYCLES, 100000: cycle_count value above which capture stops and timeout sets.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset. Synchronous, active-low.
- pc, in, 16: PC of the committing instruction.
- reg_write, in, 1: register file write this cycle.
- write_reg, in, 4: destination register.
- write_data, in, 16: register write data.
- mem_read, in, 1: load this cycle.
- mem_write, in, 1: store this cycle.
- mem_addr, in, 16: memory address (ALU result).
- mem_data, in, 16: store data.
- hlt, in, 1: halt committing this cycle.
- rec_valid, out, 1: head record available.
- rec_ready, in, 1: sink accepts the head record.
- rec_kind, out, 2: 0 NOP, 1 REG, 2 STORE, 3 HALT.
- rec_load, out, 1: REG record came from a load; rec_addr is valid.
- rec_pc, out, 16: recorded PC.
- rec_reg, out, 4: recorded register (0 unless REG).
- rec_value, out, 16: write_data for REG, mem_data for STORE, else 0.
- rec_addr, out, 16: mem_addr for loads and STORE, else 0.
- rec_inum, out, 32: instruction number, starting at 0.
- rec_cycle, out, 32: cycle timestamp; see Optional Feature.
- cycle_count, out, 32: cycles since reset release.
- inst_count, out, 32: records captured.
- overflow, out, 1: sticky; at least one record was dropped.
- timeout, out, 1: sticky.
- done, out, 1: halt record drained, or timeout.

Behaviour:
- Reset values:
  - All outputs 0; FIFO empty; state RUN.
  - Reset asserted mid-operation discards all queued records on that edge.
- Capture:
  - In RUN, one record is captured on every posedge.
  - Kind priority: reg_write, then hlt, then mem_write, then NOP. A reg_write together with hlt yields REG, and the halt is taken on its own cycle only.
  - cycle_count increments on every posedge in RUN and TIMEOUT-free DRAIN; it saturates at 2^32-1.
  - inst_count increments per attempted capture. rec_inum = inst_count before that increment, so dropped records leave gaps in numbering.
- FIFO:
  - A captured record first appears at rec_valid on the following cycle; there is no bypass.
  - A pop occurs when rec_valid && rec_ready.
  - When full, a push in the same cycle as a pop succeeds.
  - When full with no pop, the record is dropped and overflow sets. Counters still advance.
  - Head fields hold stable while rec_valid && !rec_ready.
- FSM:
  - RUN -> DRAIN when a HALT record is captured. DRAIN ignores all commit inputs.
  - DRAIN -> DONE when the FIFO is empty and no pop is pending; done=1 from then on.
  - RUN -> DONE when cycle_count would exceed MAX_CYCLES: timeout=1, no capture that cycle, queued records are discarded, rec_valid=0.
  - DONE is absorbing until reset.
- Load detection: rec_load = reg_write && mem_read at capture.

Optional Feature:
- Macro: RETIRE_TRACE_CYCLE_EN.
- Defined: each FIFO entry stores cycle_count at capture, and rec_cycle presents it for the head record.
- Undefined: the field is not stored (narrower FIFO) and rec_cycle is constant 0.

Decomposition:
- Package retire_trace_pkg holds:
  - kind constants KIND_NOP, KIND_REG, KIND_STORE, KIND_HALT;
  - the record-width localparam (conditional on the macro);
  - the FSM state encoding.
- Sub-module trace_fifo: generic WIDTH/DEPTH synchronous FIFO with push, pop, full, empty and simultaneous push/pop-when-full support.
- Classification and FSM stay in the top module.

Test Plan:
- Reset release; reg_write=1, write_reg=3, write_data=0x0005, pc=0x0000, rec_ready=1 -> next cycle rec_valid=1, kind=1, rec_reg=3, rec_value=0x0005, rec_inum=0.
- Load: reg_write=1, mem_read=1, mem_addr=0x0010 -> rec_load=1, rec_addr=0x0010. Store: mem_write=1, mem_addr=0x0020, mem_data=0xBEEF -> kind=2, rec_value=0xBEEF.
- rec_ready=0 for 20 cycles with DEPTH=16 -> 16 records held, overflow=1; rec_inum of the drained records runs 0..15 with no reorder.
- Full FIFO, rec_ready=1 for one cycle while capturing -> the push is accepted and overflow stays 0.
- hlt at cycle 5 with 3 records queued, rec_ready=1 -> HALT is the last record; done asserts after the FIFO empties; later inputs produce no records.
- MAX_CYCLES=50, no hlt -> timeout=1 and done=1 at cycle 51; rec_valid=0 thereafter. With RETIRE_TRACE_CYCLE_EN defined, rec_cycle equals the capture-cycle count on each record.

Source files
------------

// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retire trace buffer: record kinds, FSM states, record layout.
// RETIRE_TRACE_CYCLE_EN adds a 32-bit capture-cycle stamp to every record.
package retire_trace_pkg;

  localparam logic [1:0] KIND_NOP   = 2'd0;
  localparam logic [1:0] KIND_REG   = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;
  localparam logic [1:0] KIND_HALT  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic        load;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic [15:0] value;
    logic [15:0] addr;
    logic [31:0] inum;
`ifdef RETIRE_TRACE_CYCLE_EN
    logic [31:0] cycle;
`endif
  } trace_rec_t;

`ifdef RETIRE_TRACE_CYCLE_EN
  localparam int REC_W = 119;
`else
  localparam int REC_W = 87;
`endif

  // A register write wins over a halt so the halt only retires on its own cycle.
  function automatic logic [1:0] classify(input logic reg_write, input logic hlt,
                                          input logic mem_write);
    if (reg_write)      return KIND_REG;
    else if (hlt)       return KIND_HALT;
    else if (mem_write) return KIND_STORE;
    else                return KIND_NOP;
  endfunction

endpackage

// File: rtl/retire_trace_buffer_fifo.sv
// Generic synchronous FIFO; registered storage, combinational head read.
// A push while full is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop_ok)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures one classified commit record per cycle into a FIFO drained over valid/ready.
// Define RETIRE_TRACE_CYCLE_EN to stamp each record with its capture cycle.
module retire_trace_buffer
  import retire_trace_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        reg_write,
  input  logic [3:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        hlt,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [1:0]  rec_kind,
  output logic        rec_load,
  output logic [15:0] rec_pc,
  output logic [3:0]  rec_reg,
  output logic [15:0] rec_value,
  output logic [15:0] rec_addr,
  output logic [31:0] rec_inum,
  output logic [31:0] rec_cycle,
  output logic [31:0] cycle_count,
  output logic [31:0] inst_count,
  output logic        overflow,
  output logic        timeout,
  output logic        done
);

  state_t           state, state_nxt;
  trace_rec_t       cap_rec;
  trace_rec_t       head_rec;
  logic [REC_W-1:0] head_bits;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             capture;
  logic             timeout_hit;

  assign timeout_hit = (state == ST_RUN) && (cycle_count >= MAX_CYCLES);
  assign capture     = (state == ST_RUN) && !timeout_hit;
  assign rec_valid   = !fifo_empty;
  assign pop         = rec_valid && rec_ready;
  assign done        = (state == ST_DONE);

  always_comb begin
    cap_rec      = '0;
    cap_rec.kind = classify(reg_write, hlt, mem_write);
    cap_rec.pc   = pc;
    cap_rec.inum = inst_count;
`ifdef RETIRE_TRACE_CYCLE_EN
    cap_rec.cycle = cycle_count;
`endif
    if (cap_rec.kind == KIND_REG) begin
      cap_rec.load  = mem_read;
      cap_rec.rd    = write_reg;
      cap_rec.value = write_data;
      cap_rec.addr  = mem_read ? mem_addr : 16'h0000;
    end else if (cap_rec.kind == KIND_STORE) begin
      cap_rec.value = mem_data;
      cap_rec.addr  = mem_addr;
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (timeout_hit),
    .push    (capture),
    .wr_data (cap_rec),
    .pop     (pop),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Blank the head when empty so stale storage never leaks onto the record port.
  assign head_rec  = fifo_empty ? '0 : head_bits;
  assign rec_kind  = head_rec.kind;
  assign rec_load  = head_rec.load;
  assign rec_pc    = head_rec.pc;
  assign rec_reg   = head_rec.rd;
  assign rec_value = head_rec.value;
  assign rec_addr  = head_rec.addr;
  assign rec_inum  = head_rec.inum;
`ifdef RETIRE_TRACE_CYCLE_EN
  assign rec_cycle = head_rec.cycle;
`else
  assign rec_cycle = 32'h0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (timeout_hit)                      state_nxt = ST_DONE;
        else if (cap_rec.kind == KIND_HALT)   state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (fifo_empty)               state_nxt = ST_DONE;
      default:                                state_nxt = ST_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      cycle_count <= '0;
      inst_count  <= '0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != ST_DONE && cycle_count != 32'hFFFF_FFFF)
        cycle_count <= cycle_count + 32'd1;
      if (capture)
        inst_count <= inst_count + 32'd1;
      if (capture && fifo_full && !pop)
        overflow <= 1'b1;
      if (timeout_hit)
        timeout <= 1'b1;
    end
  end

endmodule
